// File: rtl/spi_byte_streamer_if.sv
// Signal bundle between the byte streamer and its surroundings.
// The streamer connects through the "slave" modport. The environment, meaning the
// host byte port plus the SPI master, connects through the "master" modport.
interface spi_byte_streamer_if;
    // Host byte port
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_full;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rx_empty;
    logic       busy;
    logic       timeout_err;
    logic       clr_err;

    // SPI master byte port
    logic       spi_tx_en;
    logic [7:0] spi_tx_byte;
    logic [7:0] spi_rx_byte;
    logic       spi_done;

    // View used by the streamer
    modport slave (
        input  wr_en, wr_data, rd_en, clr_err, spi_rx_byte, spi_done,
        output tx_full, rd_data, rx_empty, busy, timeout_err, spi_tx_en, spi_tx_byte
    );

    // View used by the host and the SPI master
    modport master (
        output wr_en, wr_data, rd_en, clr_err, spi_rx_byte, spi_done,
        input  tx_full, rd_data, rx_empty, busy, timeout_err, spi_tx_en, spi_tx_byte
    );
endinterface

// File: rtl/spi_byte_streamer.sv
// Byte-stream front end for an SPI master.
// Host bytes are queued in a TX FIFO and handed to the master one at a time.
// Each byte returned by the master is queued in an RX FIFO for the host to drain.
// A transfer that never completes is abandoned after TIMEOUT cycles, and a sticky error flag is raised.
module spi_byte_streamer #(
    parameter int DEPTH      = 4,   // entries per FIFO, power of 2, >= 2
    parameter int GAP_CYCLES = 2,   // idle cycles between bytes
    parameter int TIMEOUT    = 64   // XFER cycles allowed before abort, >= 1
) (
    input  logic               sysClk,
    input  logic               reset,
    spi_byte_streamer_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        XFER  = 3'd2,
        STORE = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t state, next_state;

    // FIFO storage and bookkeeping
    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [CW-1:0] tx_count, rx_count;

    // Transfer datapath
    logic [7:0]    tx_byte_q;
    logic          tx_en_q;
    logic [7:0]    rx_hold;
    logic [TW-1:0] timeout_cnt;
    logic [GW-1:0] gap_cnt;
    logic          err_q;

    // Decoded strobes and status
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic done_hit, timeout_hit;

    // State register
    always_ff @(posedge sysClk) begin
        // NOTE: registers use non-blocking assignments so that every flop samples pre-edge values.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode
    always_comb begin
        // NOTE: the default first assignment covers every path, so no latch can be inferred.
        next_state = state;
        unique case (state)
            IDLE: begin
                // An RX slot must be free before starting, so a stored byte can never overflow.
                if (!tx_empty && !rx_full) begin
                    next_state = LOAD;
                end
            end
            LOAD: next_state = XFER;
            XFER: begin
                if (done_hit) begin
                    next_state = STORE;
                end else if (timeout_hit) begin
                    next_state = GAP;
                end
            end
            STORE: next_state = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP: begin
                // A timeout can reach GAP with a zero count when GAP_CYCLES is 0, so treat <=1 as last.
                if (gap_cnt <= GW'(1)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output and strobe decode
    always_comb begin
        tx_empty    = (tx_count == '0);
        tx_full     = (tx_count == CW'(DEPTH));
        rx_empty    = (rx_count == '0);
        rx_full     = (rx_count == CW'(DEPTH));
        tx_push     = bus.wr_en && !tx_full;
        tx_pop      = (state == LOAD);
        rx_push     = (state == STORE);
        rx_pop      = bus.rd_en && !rx_empty;
        done_hit    = (state == XFER) && bus.spi_done;
        timeout_hit = (state == XFER) && !bus.spi_done && (timeout_cnt == TW'(TIMEOUT - 1));

        bus.tx_full     = tx_full;
        bus.rx_empty    = rx_empty;
        bus.rd_data     = rx_mem[rx_rd_ptr];
        bus.busy        = (state != IDLE);
        bus.timeout_err = err_q;
        bus.spi_tx_en   = tx_en_q;
        bus.spi_tx_byte = tx_byte_q;
    end

    // TX FIFO storage
    always_ff @(posedge sysClk) begin
        // NOTE: FIFO memories are not reset. Pointers and counts define validity, so stale contents are never observed.
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= bus.wr_data;
        end
    end

    // TX FIFO pointers and occupancy. A push and a pop on the same edge both take effect.
    always_ff @(posedge sysClk) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + AW'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + AW'(1);
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CW'(1);
                2'b01:   tx_count <= tx_count - CW'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    // RX FIFO storage
    always_ff @(posedge sysClk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_hold;
        end
    end

    // RX FIFO pointers and occupancy. A store and a host read on the same edge leave the count unchanged.
    always_ff @(posedge sysClk) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + AW'(1);
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + AW'(1);
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CW'(1);
                2'b01:   rx_count <= rx_count - CW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // Master-facing byte, enable, and captured reply
    always_ff @(posedge sysClk) begin
        if (reset) begin
            tx_byte_q <= 8'h00;
            tx_en_q   <= 1'b0;
            rx_hold   <= 8'h00;
        end else begin
            if (tx_pop) begin
                tx_byte_q <= tx_mem[tx_rd_ptr];
            end
            // The enable is high exactly while the FSM sits in XFER.
            tx_en_q <= (next_state == XFER);
            if (done_hit) begin
                rx_hold <= bus.spi_rx_byte;
            end
        end
    end

    // Timeout counter, gap counter and sticky error flag
    always_ff @(posedge sysClk) begin
        if (reset) begin
            timeout_cnt <= '0;
            gap_cnt     <= '0;
            err_q       <= 1'b0;
        end else begin
            if (state == LOAD) begin
                timeout_cnt <= '0;
            end else if (state == XFER && !done_hit && !timeout_hit) begin
                timeout_cnt <= timeout_cnt + TW'(1);
            end

            if (state == STORE || timeout_hit) begin
                gap_cnt <= GW'(GAP_CYCLES);
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end

            // When a new timeout and a clear arrive on the same edge, the timeout wins.
            if (timeout_hit) begin
                err_q <= 1'b1;
            end else if (bus.clr_err) begin
                err_q <= 1'b0;
            end
        end
    end

endmodule
